pc_sequencer: RTL and testbench

//   Owns the program counter of the multi-cycle CPU and sequences instruction fetch.
//   - Issues word-addressed fetches and latches the instruction register (IR).
//   - Waits for the control unit to finish each instruction, then selects the next PC.

---
 rtl/pc_seq_pkg.sv | 25 ++
 rtl/pc_sequencer_if.sv | 19 +
 rtl/pc_next_mux.sv | 63 ++++++
 rtl/pc_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared types and constants for the program-counter sequencer:
//   state_e : sequencer FSM states (fetch, execute-wait, PC update)
//   sel_e   : next-PC source select
//   PC_INC  : sequential increment (word addressing, so one word = 1)
// -----------------------------------------------------------------------------
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_UPDATE
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_EXC
    } sel_e;

    localparam int unsigned PC_INC = 1;

endpackage : pc_seq_pkg

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Instruction-memory fetch port between the PC sequencer and the memory.
//   req  : fetch request, held until ack          (master -> slave)
//   addr : fetch word address                     (master -> slave)
//   ack  : fetch complete, data valid this cycle  (slave -> master)
//   data : fetched instruction                    (slave -> master)
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                req;
    logic [PC_WIDTH-1:0] addr;
    logic                ack;
    logic [PC_WIDTH-1:0] data;

    modport master (output req, addr, input  ack, data);
    modport slave  (input  req, addr, output ack, data);
endinterface : pc_sequencer_if

// File: rtl/pc_next_mux.sv
// -----------------------------------------------------------------------------
// pc_next_mux
// Combinational next-PC selection: exception > jump > branch > PC+1.
// PC+1 wraps modulo 2^PC_WIDTH; targets pass through unaltered.
// Optional feature macro: PC_SEQ_EXC_EN adds the exception input/select.
// Ports:
//   i_pc            current PC
//   i_branch_taken  branch select, i_branch_target its destination
//   i_jump          jump select,   i_jump_target   its destination
//   i_exc           exception select (PC_SEQ_EXC_EN only)
//   o_exc_sel       exception path chosen (PC_SEQ_EXC_EN only)
//   o_next_pc       selected next PC
// -----------------------------------------------------------------------------
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR = PC_WIDTH'(32'h0000_0020)
) (
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic                i_branch_taken,
    input  logic [PC_WIDTH-1:0] i_branch_target,
    input  logic                i_jump,
    input  logic [PC_WIDTH-1:0] i_jump_target,
`ifdef PC_SEQ_EXC_EN
    input  logic                i_exc,
    output logic                o_exc_sel,
`endif
    output logic [PC_WIDTH-1:0] o_next_pc
);

    sel_e sel;

    // Lowest priority first; later assignments override earlier ones.
    always_comb begin
        sel = SEL_SEQ;
        if (i_jump) begin
            sel = SEL_JMP;
        end else if (i_branch_taken) begin
            sel = SEL_BR;
        end
`ifdef PC_SEQ_EXC_EN
        if (i_exc) begin
            sel = SEL_EXC;
        end
`endif
    end

    always_comb begin
        unique case (sel)
            SEL_SEQ: o_next_pc = i_pc + PC_WIDTH'(PC_INC);
            SEL_BR:  o_next_pc = i_branch_target;
            SEL_JMP: o_next_pc = i_jump_target;
            SEL_EXC: o_next_pc = EXC_VECTOR;
            default: o_next_pc = i_pc + PC_WIDTH'(PC_INC);
        endcase
    end

`ifdef PC_SEQ_EXC_EN
    assign o_exc_sel = (sel == SEL_EXC);
`endif

endmodule : pc_next_mux

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter of the multi-cycle CPU: fetches the instruction at
// the PC, latches it into the IR, waits for the control unit to finish, then
// loads the next PC (sequential, branch, jump or exception vector).
// Optional feature macro: PC_SEQ_EXC_EN (exception request i_exc, o_epc).
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   imem                      fetch port (req/addr out, ack/data in)
//   o_ir, o_ir_valid          instruction register, 1-cycle load pulse
//   i_instr_done              control FSM finished the instruction
//   i_stall                   freeze sequencer
//   i_branch_taken/_target    branch request and word target
//   i_jump/i_jump_target      jump request and word target
//   i_exc, o_epc              exception request, faulting PC (feature only)
//   o_pc                      current PC
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(32'h0000_0000),
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR = PC_WIDTH'(32'h0000_0020)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    pc_sequencer_if.master      imem,
    output logic [PC_WIDTH-1:0] o_ir,
    output logic                o_ir_valid,
    input  logic                i_instr_done,
    input  logic                i_stall,
    input  logic                i_branch_taken,
    input  logic [PC_WIDTH-1:0] i_branch_target,
    input  logic                i_jump,
    input  logic [PC_WIDTH-1:0] i_jump_target,
`ifdef PC_SEQ_EXC_EN
    input  logic                i_exc,
    output logic [PC_WIDTH-1:0] o_epc,
`endif
    output logic [PC_WIDTH-1:0] o_pc
);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] ir_q, ir_d;
    logic                ir_valid_q, ir_valid_d;
    logic                req_q, req_d;
    logic [PC_WIDTH-1:0] npc_q, npc_d;
    // An ack or a done that arrives while stalled is parked here and acted on
    // once the stall drops.
    logic                ack_pend_q, ack_pend_d;
    logic [PC_WIDTH-1:0] ir_buf_q, ir_buf_d;
    logic                done_pend_q, done_pend_d;
    logic [PC_WIDTH-1:0] next_pc;
    logic                done_now;
    logic                ack_ok;
`ifdef PC_SEQ_EXC_EN
    logic                exc_sel;
    logic                exc_sel_q, exc_sel_d;
    logic [PC_WIDTH-1:0] epc_q, epc_d;
`endif

    pc_next_mux #(
        .PC_WIDTH   (PC_WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_mux (
        .i_pc            (pc_q),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
`ifdef PC_SEQ_EXC_EN
        .i_exc           (i_exc),
        .o_exc_sel       (exc_sel),
`endif
        .o_next_pc       (next_pc)
    );

`ifdef PC_SEQ_EXC_EN
    assign done_now = i_instr_done | i_exc;
`else
    assign done_now = i_instr_done;
`endif
    // Acks are only meaningful while a request is outstanding.
    assign ack_ok = req_q & imem.ack;

    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_valid_d  = 1'b0;
        req_d       = req_q;
        npc_d       = npc_q;
        ack_pend_d  = ack_pend_q;
        ir_buf_d    = ir_buf_q;
        done_pend_d = done_pend_q;
`ifdef PC_SEQ_EXC_EN
        exc_sel_d   = exc_sel_q;
        epc_d       = epc_q;
`endif
        if (i_stall) begin
            if (state_q == S_FETCH && ack_ok && !ack_pend_q) begin
                ack_pend_d = 1'b1;
                ir_buf_d   = imem.data;
            end
            if (state_q == S_EXEC && done_now && !done_pend_q) begin
                done_pend_d = 1'b1;
                npc_d       = next_pc;
`ifdef PC_SEQ_EXC_EN
                exc_sel_d   = exc_sel;
`endif
            end
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (ack_pend_q || ack_ok) begin
                        ir_d       = ack_pend_q ? ir_buf_q : imem.data;
                        ir_valid_d = 1'b1;
                        ack_pend_d = 1'b0;
                        req_d      = 1'b0;
                        state_d    = S_EXEC;
                    end else begin
                        req_d = 1'b1;
                    end
                end
                S_EXEC: begin
                    req_d = 1'b0;
                    if (done_pend_q) begin
                        done_pend_d = 1'b0;
                        state_d     = S_UPDATE;
                    end else if (done_now) begin
                        npc_d   = next_pc;
`ifdef PC_SEQ_EXC_EN
                        exc_sel_d = exc_sel;
`endif
                        state_d = S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    pc_d    = npc_q;
`ifdef PC_SEQ_EXC_EN
                    if (exc_sel_q) begin
                        epc_d = pc_q;
                    end
`endif
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            req_q       <= 1'b0;
            npc_q       <= '0;
            ack_pend_q  <= 1'b0;
            ir_buf_q    <= '0;
            done_pend_q <= 1'b0;
`ifdef PC_SEQ_EXC_EN
            exc_sel_q   <= 1'b0;
            epc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            req_q       <= req_d;
            npc_q       <= npc_d;
            ack_pend_q  <= ack_pend_d;
            ir_buf_q    <= ir_buf_d;
            done_pend_q <= done_pend_d;
`ifdef PC_SEQ_EXC_EN
            exc_sel_q   <= exc_sel_d;
            epc_q       <= epc_d;
`endif
        end
    end

    assign imem.req   = req_q;
    assign imem.addr  = pc_q;
    assign o_ir       = ir_q;
    assign o_ir_valid = ir_valid_q;
    assign o_pc       = pc_q;
`ifdef PC_SEQ_EXC_EN
    assign o_epc      = epc_q;
`endif

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer. Expected fetch addresses are queued
// when a next-PC decision is driven and popped when the DUT raises a fetch;
// expected IR values are queued when an ack is driven and popped on o_ir_valid.
// Builds with or without PC_SEQ_EXC_EN.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] o_ir;
    logic         o_ir_valid;
    logic         instr_done = 1'b0;
    logic         stall = 1'b0;
    logic         branch_taken = 1'b0;
    logic [W-1:0] branch_target = '0;
    logic         jump = 1'b0;
    logic [W-1:0] jump_target = '0;
    logic [W-1:0] o_pc;
`ifdef PC_SEQ_EXC_EN
    logic         exc = 1'b0;
    logic [W-1:0] o_epc;
`endif

    pc_sequencer_if #(.PC_WIDTH(W)) imem_bus ();

    pc_sequencer #(
        .PC_WIDTH   (W),
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0020)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .imem            (imem_bus),
        .o_ir            (o_ir),
        .o_ir_valid      (o_ir_valid),
        .i_instr_done    (instr_done),
        .i_stall         (stall),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
`ifdef PC_SEQ_EXC_EN
        .i_exc           (exc),
        .o_epc           (o_epc),
`endif
        .o_pc            (o_pc)
    );

    always #5 clk = ~clk;

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_addr_q[$];
    logic [W-1:0] exp_ir_q[$];
    logic [W-1:0] model_pc;
    logic [W-1:0] model_ir;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_addr(output logic [W-1:0] a);
        if (exp_addr_q.size() > 0) a = exp_addr_q.pop_front();
        else a = 'x;
    endtask

    // Serve one fetch: wait for the request, check the address, ack with instr.
    task automatic do_fetch(input logic [W-1:0] instr);
        int           n = 0;
        logic [W-1:0] ea;
        logic [W-1:0] ei;
        while (imem_bus.req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("fetch_req", {31'b0, imem_bus.req}, 32'd1);
        pop_addr(ea);
        check("fetch_addr", imem_bus.addr, ea);
        exp_ir_q.push_back(instr);
        imem_bus.ack  = 1'b1;
        imem_bus.data = instr;
        tick();
        imem_bus.ack  = 1'b0;
        imem_bus.data = '0;
        check("ir_valid_pulse", {31'b0, o_ir_valid}, 32'd1);
        if (o_ir_valid === 1'b1 && exp_ir_q.size() > 0) ei = exp_ir_q.pop_front();
        else ei = 'x;
        check("ir_value", o_ir, ei);
        model_ir = instr;
        check("req_drop_after_ack", {31'b0, imem_bus.req}, 32'd0);
        tick();
        check("ir_valid_clear", {31'b0, o_ir_valid}, 32'd0);
    endtask

    // Finish the instruction with the given next-PC request; expect the new PC
    // two edges later and a fresh fetch request.
    task automatic do_done(input logic br, input logic [W-1:0] bt,
                           input logic jmp, input logic [W-1:0] jt);
        logic [W-1:0] prev;
        prev = model_pc;
        if (jmp) model_pc = jt;
        else if (br) model_pc = bt;
        else model_pc = model_pc + 32'd1;
        exp_addr_q.push_back(model_pc);
        instr_done    = 1'b1;
        branch_taken  = br;
        branch_target = bt;
        jump          = jmp;
        jump_target   = jt;
        tick();
        instr_done    = 1'b0;
        branch_taken  = 1'b0;
        jump          = 1'b0;
        check("pc_before_load", o_pc, prev);
        tick();
        check("pc_after_done", o_pc, model_pc);
        check("req_refetch", {31'b0, imem_bus.req}, 32'd1);
    endtask

    initial begin
        logic [W-1:0] ea;
        imem_bus.ack  = 1'b0;
        imem_bus.data = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'b0, imem_bus.req}, 32'd0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_ir", o_ir, 32'h0);
        check("rst_ir_valid", {31'b0, o_ir_valid}, 32'd0);
`ifdef PC_SEQ_EXC_EN
        check("rst_epc", o_epc, 32'h0);
`endif
        model_pc = 32'h0;
        model_ir = 32'h0;
        exp_addr_q.push_back(32'h0);
        rst_n = 1'b1;

        // 1: first fetch and sequential advance
        do_fetch(32'h0000_1234);
        do_done(1'b0, 32'h0, 1'b0, 32'h0);

        // 2: ack with no outstanding request is ignored; then branch/jump
        do_fetch(32'h0000_000A);
        imem_bus.ack  = 1'b1;
        imem_bus.data = 32'hDEAD_BEEF;
        tick();
        imem_bus.ack  = 1'b0;
        imem_bus.data = '0;
        check("stray_ack_ir", o_ir, model_ir);
        check("stray_ack_valid", {31'b0, o_ir_valid}, 32'd0);
        do_done(1'b0, 32'h0, 1'b1, 32'h10);
        do_fetch(32'h0000_000B);
        do_done(1'b1, 32'h80, 1'b0, 32'h0);

        // done while fetching is ignored
        instr_done  = 1'b1;
        jump        = 1'b1;
        jump_target = 32'h99;
        tick();
        instr_done  = 1'b0;
        jump        = 1'b0;
        tick();
        tick();
        check("done_in_fetch_pc", o_pc, model_pc);

        do_fetch(32'h0000_000C);
        do_done(1'b1, 32'h80, 1'b1, 32'h40);

        // 3: wrap at all-ones
        do_fetch(32'h0000_000D);
        do_done(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        do_fetch(32'h0000_000E);
        do_done(1'b0, 32'h0, 1'b0, 32'h0);
        do_fetch(32'h0000_000F);

        // 4: done pulse during a 5-cycle stall takes effect after the stall
        stall = 1'b1;
        tick();
        instr_done    = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h55;
        tick();
        instr_done    = 1'b0;
        branch_taken  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc_hold", o_pc, model_pc);
        end
        model_pc = 32'h55;
        exp_addr_q.push_back(model_pc);
        stall = 1'b0;
        tick();
        check("unstall_pc_not_yet", o_pc, 32'h0);
        tick();
        check("unstall_pc", o_pc, model_pc);

        // ack during stall is captured, IR updates after stall drops
        pop_addr(ea);
        check("stall_fetch_addr", imem_bus.addr, ea);
        stall         = 1'b1;
        imem_bus.ack  = 1'b1;
        imem_bus.data = 32'h0000_ABCD;
        exp_ir_q.push_back(32'h0000_ABCD);
        tick();
        imem_bus.ack  = 1'b0;
        imem_bus.data = '0;
        tick();
        check("stall_ack_ir_hold", o_ir, model_ir);
        check("stall_ack_req_hold", {31'b0, imem_bus.req}, 32'd1);
        stall = 1'b0;
        tick();
        check("stall_ack_valid", {31'b0, o_ir_valid}, 32'd1);
        check("stall_ack_ir", o_ir, (exp_ir_q.size() > 0) ? exp_ir_q.pop_front() : 32'hx);
        check("stall_ack_req_drop", {31'b0, imem_bus.req}, 32'd0);
        model_ir = 32'h0000_ABCD;
        do_done(1'b0, 32'h0, 1'b0, 32'h0);

        // 5: reset in the middle of a fetch; the late ack is discarded
        check("pre_reset_req", {31'b0, imem_bus.req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", {31'b0, imem_bus.req}, 32'd0);
        check("async_rst_pc", o_pc, 32'h0);
        imem_bus.ack  = 1'b1;
        imem_bus.data = 32'h0000_0BAD;
        tick();
        rst_n = 1'b1;
        tick();
        imem_bus.ack  = 1'b0;
        imem_bus.data = '0;
        check("late_ack_ir", o_ir, 32'h0);
        check("late_ack_valid", {31'b0, o_ir_valid}, 32'd0);
        exp_addr_q.delete();
        exp_ir_q.delete();
        model_pc = 32'h0;
        model_ir = 32'h0;
        exp_addr_q.push_back(32'h0);
        do_fetch(32'h0000_0077);

        // 6: exception (or plain sequential step without the feature)
        do_done(1'b0, 32'h0, 1'b1, 32'h22);
        do_fetch(32'h0000_0088);
`ifdef PC_SEQ_EXC_EN
        exc = 1'b1;
        tick();
        exc = 1'b0;
        check("exc_pc_before", o_pc, 32'h22);
        tick();
        check("exc_pc_vector", o_pc, 32'h20);
        check("exc_epc", o_epc, 32'h22);
        model_pc = 32'h20;
        exp_addr_q.push_back(model_pc);
`else
        do_done(1'b0, 32'h0, 1'b0, 32'h0);
        check("seq_after_22", o_pc, 32'h23);
`endif
        do_fetch(32'h0000_0099);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule : tb_pc_sequencer
